// File: rtl/fmul_special_pipe.sv
// fmul_special_pipe: pipelined FMUL special-case resolver (sign, one-hot class, invalid, biased exponent sum)
// Optional sticky flags are built only when FMUL_SPEC_FLAGS_EN is defined; otherwise flags read 2'b00.
module fmul_special_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     res_sign,
    output logic [3:0]               res_class,
    output logic                     res_inv,
    output logic [EXP_W+1:0]         res_exp,
    input  logic                     flag_clr,
    output logic [1:0]               flags
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int PW = EXP_W + 8;
    localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic za, zb, ia, ib, na, nb, sna, snb, zinf;
    logic nan_c, inf_c, zero_c, norm_c, inv_c, sgn_x, sgn;
    logic [EXP_W+1:0] exp_c;
    logic [PW-1:0] in_word;

    assign ea = op_a[W-2 -: EXP_W];
    assign eb = op_b[W-2 -: EXP_W];
    assign ma = op_a[MAN_W-1:0];
    assign mb = op_b[MAN_W-1:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea & (ma == '0);
    assign ib = &eb & (mb == '0);
    assign na = &ea & |ma;
    assign nb = &eb & |mb;
    assign sna = na & ~ma[MAN_W-1];
    assign snb = nb & ~mb[MAN_W-1];
    assign zinf = (za & ib) | (ia & zb);
    assign nan_c = na | nb | zinf;
    assign inf_c = ~nan_c & (ia | ib);
    assign zero_c = ~nan_c & ~inf_c & (za | zb);
    assign norm_c = ~(nan_c | inf_c | zero_c);
    assign inv_c = sna | snb | zinf;
    assign sgn_x = op_a[W-1] ^ op_b[W-1];
    assign sgn = mode == 2'b10 ? 1'b0 : mode == 2'b01 ? ~sgn_x : sgn_x;
    assign exp_c = {2'b00, ea} + {2'b00, eb} - BIAS;
    assign in_word = {sgn, nan_c, inf_c, zero_c, norm_c, inv_c, exp_c};

    logic [STAGES-1:0] v, ld;
    logic [STAGES-1:0][PW-1:0] d;
    logic acc;

    // A stage may load when it is empty or everything downstream of it is about to move.
    always_comb begin
        ld = '0;
        acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~v[k] | acc;
            acc = ld[k];
        end
    end

    // Shift valid bits and payloads forward; payloads only update when a real word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            d <= '0;
        end else begin
            if (ld[0]) v[0] <= in_valid;
            if (ld[0] & in_valid) d[0] <= in_word;
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) v[k] <= v[k-1];
                if (ld[k] & v[k-1]) d[k] <= d[k-1];
            end
        end
    end

    assign in_ready = ld[0];
    assign out_valid = v[STAGES-1];
    assign {res_sign, res_class, res_inv, res_exp} = d[STAGES-1];

`ifdef FMUL_SPEC_FLAGS_EN
    logic [1:0] flg;

    // Sticky flags latch on each delivered result; a same-cycle set overrides a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flg <= 2'b00;
        else flg <= (flag_clr ? 2'b00 : flg) | ({res_inv, res_class[2]} & {2{out_valid & out_ready}});
    end

    assign flags = flg;
`else
    logic unused_clr;
    assign unused_clr = flag_clr;
    assign flags = 2'b00;
`endif
endmodule

// File: tb/tb_fmul_special_pipe.sv
// tb_fmul_special_pipe: random and directed checks of fmul_special_pipe against a spec-level model
module tb_fmul_special_pipe;
    typedef struct packed {
        logic       s;
        logic [3:0] c;
        logic       inv;
        logic [9:0] e;
    } res_t;

`ifdef FMUL_SPEC_FLAGS_EN
    localparam logic [1:0] F_ZINF = 2'b10;
    localparam logic [1:0] F_ALL  = 2'b11;
`else
    localparam logic [1:0] F_ZINF = 2'b00;
    localparam logic [1:0] F_ALL  = 2'b00;
`endif

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, flag_clr = 0;
    logic in_ready, out_valid, res_sign, res_inv;
    logic [31:0] op_a = 0, op_b = 0;
    logic [1:0] mode = 0, flags;
    logic [3:0] res_class;
    logic [9:0] res_exp;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    fmul_special_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .res_sign(res_sign), .res_class(res_class), .res_inv(res_inv), .res_exp(res_exp),
        .flag_clr(flag_clr), .flags(flags)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // 0 zero, 1 inf, 2 qnan, 3 snan, 4 normal
    function automatic int kind(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 0;
        if (x[30:23] != 8'hFF) return 4;
        if (x[22:0] == 0) return 1;
        return x[22] ? 2 : 3;
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        res_t r;
        int ka, kb;
        bit zinf, anynan;
        ka = kind(a);
        kb = kind(b);
        zinf = (ka == 0 && kb == 1) || (ka == 1 && kb == 0);
        anynan = ka == 2 || ka == 3 || kb == 2 || kb == 3;
        r.s = (m == 2'd2) ? 1'b0 : (m == 2'd1) ? ~(a[31] ^ b[31]) : (a[31] ^ b[31]);
        if (anynan || zinf) r.c = 4'b1000;
        else if (ka == 1 || kb == 1) r.c = 4'b0100;
        else if (ka == 0 || kb == 0) r.c = 4'b0010;
        else r.c = 4'b0001;
        r.inv = ka == 3 || kb == 3 || zinf;
        r.e = 10'(int'(a[30:23]) + int'(b[30:23]) - 127);
        return r;
    endfunction

    function automatic logic [31:0] rnd();
        logic [7:0] e;
        logic [22:0] m;
        case ($urandom_range(0, 3))
            0: e = 8'h00;
            1: e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        m = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    res_t q[$];
    res_t cur, prev, ex;
    logic [1:0] mflags = 0, fset;
    bit took = 0, prev_stall = 0;

    always @(negedge clk) begin
        cur = {res_sign, res_class, res_inv, res_exp};
        if (rst) begin
            q.delete();
            mflags = 0;
            took = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("hold_stable", cur, prev);
`ifdef FMUL_SPEC_FLAGS_EN
            chk("flags_model", flags, mflags);
`else
            chk("flags_tied", flags, 2'b00);
`endif
            fset = 0;
            if (out_valid && out_ready) begin
                chk("out_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    ex = q.pop_front();
                    chk("result", cur, ex);
                    fset = {ex.inv, ex.c[2]};
                end
            end
            mflags = (flag_clr ? 2'b00 : mflags) | fset;
            took = in_valid && in_ready;
            if (took) q.push_back(model(op_a, op_b, mode));
            prev_stall = out_valid && !out_ready;
            prev = cur;
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        int n = 0;
        op_a = a;
        op_b = b;
        mode = m;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("put_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic direct(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input res_t e);
        out_ready = 1;
        put(a, b, m);
        chk({nm, "_lat1"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_res"}, {res_sign, res_class, res_inv, res_exp}, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t held;
        int n;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", {res_sign, res_class, res_inv, res_exp}, 0);
        chk("rst_flags", flags, 0);
        @(posedge clk);
        #1 rst = 0;
        #1 chk("rst_in_ready", in_ready, 1);

        direct("mul_norm", 32'h3F800000, 32'h40000000, 2'd0, {1'b0, 4'b0001, 1'b0, 10'd128});
        chk("flags_norm", flags, 2'b00);
        direct("zero_inf", 32'h00000000, 32'hFF800000, 2'd0, {1'b1, 4'b1000, 1'b1, 10'd128});
        chk("flags_zinf", flags, F_ZINF);
        direct("snan_invs", 32'h7FA00000, 32'h3F800000, 2'd1, {1'b1, 4'b1000, 1'b1, 10'd255});
        direct("inf_absw", 32'h7F800000, 32'hC0000000, 2'd2, {1'b0, 4'b0100, 1'b0, 10'd256});
        chk("flags_both", flags, F_ALL);
        flag_clr = 1;
        @(posedge clk);
        #1 flag_clr = 0;
        chk("flags_clr", flags, 2'b00);

        out_ready = 0;
        put(32'h3F800000, 32'h40400000, 2'd0);
        put(32'hC0800000, 32'h41000000, 2'd1);
        op_a = 32'h00000000;
        op_b = 32'h40000000;
        mode = 2'd2;
        in_valid = 1;
        @(negedge clk);
        held = {res_sign, res_class, res_inv, res_exp};
        repeat (3) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_hold", {res_sign, res_class, res_inv, res_exp}, held);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_drain_empty", q.size(), 0);
        chk("stall_drain_idle", out_valid, 0);

        op_a = 32'h00000000;
        op_b = 32'h7F800000;
        mode = 2'd0;
        in_valid = 1;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_flags", flags, F_ZINF);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 1;
        in_valid = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", flags, 0);
        @(posedge clk);
        #1 rst = 0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!(in_valid && !took)) begin
                in_valid = $urandom_range(0, 9) < 7;
                op_a = rnd();
                op_b = rnd();
                mode = 2'($urandom_range(0, 3));
            end
            out_ready = $urandom_range(0, 9) < 6;
            flag_clr = $urandom_range(0, 19) == 0;
        end
        @(posedge clk);
        #1 in_valid = 0;
        out_ready = 1;
        flag_clr = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("final_drain_empty", q.size(), 0);
        chk("final_idle", out_valid, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
